seg7_scanner: RTL and testbench

//   Scan controller and value loader for the 4-digit 7-segment display; it sits on the other end of the digit-select interface from seg7_driver.

---
 rtl/seg7_pkg.sv | 19 +
 rtl/bin2bcd_seq.sv | 62 ++++++
 rtl/seg7_scanner.sv | 75 +++++++
 tb/tb_seg7_scanner.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit 7-segment scanner and its
// binary-to-BCD loader.
package seg7_pkg;
  localparam int VALUE_W    = 14;
  localparam int NUM_DIGITS = 4;
  localparam int BCD_W      = 4 * NUM_DIGITS;
  localparam logic [3:0]         BLANK_CODE = 4'hF;
  localparam logic [VALUE_W-1:0] MAX_VALUE  = 14'd9999;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_SHIFT = 2'd1,
    LD_LATCH = 2'd2
  } ld_state_e;

  function automatic logic [VALUE_W-1:0] clamp_value(input logic [VALUE_W-1:0] v);
    return (v > MAX_VALUE) ? MAX_VALUE : v;
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, 14 shift cycles
// followed by a single LATCH cycle during which done is high.
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [VALUE_W-1:0] value,
  output logic               busy,
  output logic               done,
  output logic [BCD_W-1:0]   bcd
);
  ld_state_e          state, state_nxt;
  logic [VALUE_W-1:0] bin_q;
  logic [BCD_W-1:0]   bcd_q, bcd_adj;
  logic [3:0]         cnt_q;

  always_comb begin
    state_nxt = state;
    case (state)
      LD_IDLE:  if (start) state_nxt = LD_SHIFT;
      LD_SHIFT: if (cnt_q == 4'd0) state_nxt = LD_LATCH;
      LD_LATCH: state_nxt = LD_IDLE;
      default:  state_nxt = LD_IDLE;
    endcase
  end

  // Add-3 correction on every nibble that would overflow past 9 after the shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LD_IDLE;
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        LD_IDLE: if (start) begin
          bin_q <= value;
          bcd_q <= '0;
          cnt_q <= 4'd13;
        end
        LD_SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
          cnt_q          <= cnt_q - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != LD_IDLE);
  assign done = (state == LD_LATCH);
  assign bcd  = bcd_q;
endmodule

// File: rtl/seg7_scanner.sv
// Value loader and digit scanner for a 4-digit multiplexed 7-segment display.
// The scan free-runs; the display register only changes when a conversion latches.
module seg7_scanner
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV   = 1000,
  parameter int BLANK_LEADING = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               value_valid,
  input  logic [VALUE_W-1:0] value,
  output logic               value_ready,
  output logic               bcd_done,
  output logic [1:0]         digit_select,
  output logic [3:0]         an,
  output logic [3:0]         digit_bcd,
  output logic               blank
);
  localparam int PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);

  logic                            cvt_busy, cvt_done, start;
  logic [BCD_W-1:0]                cvt_bcd;
  logic [NUM_DIGITS-1:0][3:0]      display_q;
  logic [PRESC_W-1:0]              presc_q;
  logic [NUM_DIGITS-1:0]           lead_zero;

  assign value_ready = !cvt_busy;
  assign start       = value_valid && value_ready;

  bin2bcd_seq u_cvt (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .value (clamp_value(value)),
    .busy  (cvt_busy),
    .done  (cvt_done),
    .bcd   (cvt_bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display_q <= '0;
      bcd_done  <= 1'b0;
    end else begin
      bcd_done <= cvt_done;
      if (cvt_done) display_q <= cvt_bcd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      digit_select <= 2'd0;
    end else if (presc_q == PRESC_LAST) begin
      presc_q      <= '0;
      digit_select <= digit_select + 2'd1;
    end else begin
      presc_q <= presc_q + PRESC_W'(1);
    end
  end

  // lead_zero[k]: digits k..MSB are all zero; digit 0 is never blanked
  always_comb begin
    lead_zero = '0;
    lead_zero[NUM_DIGITS-1] = (display_q[NUM_DIGITS-1] == 4'd0);
    for (int k = NUM_DIGITS - 2; k >= 1; k--)
      lead_zero[k] = lead_zero[k+1] && (display_q[k] == 4'd0);
  end

  assign blank     = (BLANK_LEADING != 0) && lead_zero[digit_select];
  assign an        = blank ? 4'b1111 : ~(4'b0001 << digit_select);
  assign digit_bcd = blank ? BLANK_CODE : display_q[digit_select];
endmodule

// File: tb/tb_seg7_scanner.sv
// Directed bench for seg7_scanner: one blanking and one non-blanking instance
// share clock, reset and load inputs.
module tb_seg7_scanner;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        value_valid = 1'b0;
  logic [13:0] value = '0;

  logic        ready_a, done_a, blank_a, ready_b, done_b, blank_b;
  logic [1:0]  ds_a, ds_b;
  logic [3:0]  an_a, bcd_a, an_b, bcd_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seg7_scanner #(.REFRESH_DIV(4), .BLANK_LEADING(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .value_valid(value_valid), .value(value),
    .value_ready(ready_a), .bcd_done(done_a), .digit_select(ds_a),
    .an(an_a), .digit_bcd(bcd_a), .blank(blank_a));

  seg7_scanner #(.REFRESH_DIV(4), .BLANK_LEADING(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .value_valid(value_valid), .value(value),
    .value_ready(ready_b), .bcd_done(done_b), .digit_select(ds_b),
    .an(an_b), .digit_bcd(bcd_b), .blank(blank_b));

  typedef struct {
    logic [13:0] value;
    logic [15:0] bcd;
    logic [3:0]  blank;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected {an, digit_bcd, blank} of the blanking instance for a display and digit
  function automatic logic [8:0] model_out(input logic [15:0] disp, input logic [1:0] ds);
    logic bl;
    int   d;
    d  = int'(ds);
    bl = (d != 0);
    for (int j = 0; j < 4; j++)
      if (j >= d && disp[j*4 +: 4] != 4'd0) bl = 1'b0;
    return {bl ? 4'b1111 : ~(4'b0001 << ds), bl ? 4'hF : disp[d*4 +: 4], bl};
  endfunction

  task automatic wait_ds(input logic [1:0] k);
    for (int i = 0; i < 40; i++) begin
      if (ds_a == k) return;
      @(posedge clk); #1;
    end
    chk("wait_digit_select_timeout", {14'd0, ds_a}, {14'd0, k});
  endtask

  task automatic check_disp(input logic [15:0] exp_bcd, input logic [3:0] mask);
    for (int k = 0; k < 4; k++) begin
      logic [3:0] onehot;
      logic [1:0] kk;
      kk = 2'(k);
      onehot = ~(4'b0001 << kk);
      wait_ds(kk);
      chk("ds_sync", {14'd0, ds_b}, {14'd0, kk});
      chk("an_a",    {12'd0, an_a},  {12'd0, mask[k] ? 4'b1111 : onehot});
      chk("bcd_a",   {12'd0, bcd_a}, {12'd0, mask[k] ? 4'hF : exp_bcd[k*4 +: 4]});
      chk("blank_a", {15'd0, blank_a}, {15'd0, mask[k]});
      chk("an_b",    {12'd0, an_b},  {12'd0, onehot});
      chk("bcd_b",   {12'd0, bcd_b}, {12'd0, exp_bcd[k*4 +: 4]});
      chk("blank_b", {15'd0, blank_b}, 16'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic load_wait(input logic [13:0] v);
    int lat;
    lat = 0;
    @(negedge clk);
    chk("ready_before_load", {15'd0, ready_a}, 16'd1);
    value_valid = 1'b1;
    value = v;
    @(posedge clk); #1;
    value_valid = 1'b0;
    chk("ready_busy", {15'd0, ready_a}, 16'd0);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done_a) begin lat = i; break; end
    end
    chk("bcd_done_latency", 16'(lat), 16'd15);
    chk("done_b", {15'd0, done_b}, 16'd1);
    chk("ready_after_done", {15'd0, ready_a}, 16'd1);
    @(posedge clk); #1;
    chk("done_pulse_1cyc", {15'd0, done_a}, 16'd0);
  endtask

  initial begin
    logic [8:0]  m;
    logic [15:0] exp_disp;
    vecs[0] = '{14'd1234,  16'h1234, 4'b0000};
    vecs[1] = '{14'd12000, 16'h9999, 4'b0000};
    vecs[2] = '{14'd0,     16'h0000, 4'b1110};
    vecs[3] = '{14'd100,   16'h0100, 4'b1000};
    vecs[4] = '{14'd9999,  16'h9999, 4'b0000};
    vecs[5] = '{14'd7,     16'h0007, 4'b1110};
    vecs[6] = '{14'd16383, 16'h9999, 4'b0000};

    // Reset and idle scan
    #12;
    @(negedge clk); rst_n = 1'b1;
    chk("rst_ready", {15'd0, ready_a}, 16'd1);
    chk("rst_done",  {15'd0, done_a},  16'd0);
    for (int i = 0; i < 5; i++) begin
      logic [1:0] e;
      e = 2'(i % 4);
      chk("idle_ds", {14'd0, ds_a}, {14'd0, e});
      chk("idle_an", {12'd0, an_a}, (e == 2'd0) ? 16'h000E : 16'h000F);
      chk("idle_bcd", {12'd0, bcd_a}, (e == 2'd0) ? 16'h0000 : 16'h000F);
      chk("idle_blank", {15'd0, blank_a}, (e == 2'd0) ? 16'd0 : 16'd1);
      repeat (4) @(posedge clk);
      #1;
    end

    // Table-driven loads
    foreach (vecs[i]) begin
      load_wait(vecs[i].value);
      check_disp(vecs[i].bcd, vecs[i].blank);
    end

    // valid pulsed during conversion is ignored
    @(negedge clk);
    value_valid = 1'b1; value = 14'd1234;
    @(posedge clk); #1;
    value_valid = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      if (c == 5) value_valid = 1'b0;
      chk("midpulse_done", {15'd0, done_a}, (c == 15) ? 16'd1 : 16'd0);
      if (c == 4) begin
        value_valid = 1'b1; value = 14'd5678;
        chk("midpulse_ready", {15'd0, ready_a}, 16'd0);
      end
    end
    check_disp(16'h1234, 4'b0000);

    // Reset mid-SHIFT
    @(negedge clk);
    value_valid = 1'b1; value = 14'd4321;
    @(posedge clk); #1;
    value_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_ds",    {14'd0, ds_a},    16'd0);
    chk("abort_an",    {12'd0, an_a},    16'h000E);
    chk("abort_bcd",   {12'd0, bcd_a},   16'd0);
    chk("abort_blank", {15'd0, blank_a}, 16'd0);
    chk("abort_ready", {15'd0, ready_a}, 16'd1);
    chk("abort_done",  {15'd0, done_a},  16'd0);
    @(negedge clk); rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        if (done_a) seen++;
      end
      chk("abort_no_done", 16'(seen), 16'd0);
    end
    check_disp(16'h0000, 4'b1110);

    // Back-to-back: 100 then 5 with valid held high
    @(negedge clk);
    value_valid = 1'b1; value = 14'd100;
    @(posedge clk); #1;
    value = 14'd5;
    for (int c = 1; c <= 32; c++) begin
      @(posedge clk); #1;
      exp_disp = (c >= 31) ? 16'h0005 : (c >= 15) ? 16'h0100 : 16'h0000;
      chk("b2b_done", {15'd0, done_a}, (c == 15 || c == 31) ? 16'd1 : 16'd0);
      m = model_out(exp_disp, ds_a);
      chk("b2b_out", {7'd0, an_a, bcd_a, blank_a}, {7'd0, m});
      if (c == 15) chk("b2b_ready", {15'd0, ready_a}, 16'd1);
      if (c == 16) begin
        chk("b2b_accepted", {15'd0, ready_a}, 16'd0);
        value_valid = 1'b0;
      end
    end
    check_disp(16'h0005, 4'b1110);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
